// File: rtl/ripple_mon_pkg.sv
`default_nettype none
// ripple_mon_pkg: shared state type and filter-counter sizing for the ripple count monitor.
package ripple_mon_pkg;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_e;

   localparam int STABLE_CYCLES_DFLT = 2;

   // A one-value filter still needs a one-bit counter.
   function automatic int stab_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   localparam int STAB_W = stab_width(STABLE_CYCLES_DFLT);

endpackage
`default_nettype wire

// File: rtl/ripple_count_monitor_sync_bus.sv
`default_nettype none
// sync_bus: W-bit two-flop synchronizer with asynchronous active-low reset.
module sync_bus #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule
`default_nettype wire

// File: rtl/ripple_count_monitor.sv
`default_nettype none
// ripple_count_monitor: synchronizes and glitch-filters a ripple counter, reporting each
// accepted change as a modular delta and accumulating a wide running total.
module ripple_count_monitor
   import ripple_mon_pkg::*;
#(
   parameter int CNT_W         = 3,
   parameter int ACC_W         = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_sync,
   output logic             valid,
   output logic             step_pulse,
   output logic [CNT_W-1:0] delta,
   output logic             wrap_pulse,
   output logic [ACC_W-1:0] total,
   output logic             total_ovf
);

   localparam int             SW       = stab_width(STABLE_CYCLES);
   localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYCLES - 1);

   logic [CNT_W-1:0] s2;
   logic [CNT_W-1:0] s2_prev_q;
   logic [2:0]       warm_q;
   logic [SW-1:0]    stab_q, stab_d;
   logic             stable;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_sync_q, cnt_sync_d;
   logic             valid_q, valid_d;
   logic             step_q, step_d;
   logic [CNT_W-1:0] delta_q, delta_d;
   logic             wrap_q, wrap_d;
   logic [ACC_W-1:0] total_q, total_d;
   logic             ovf_q, ovf_d;

   logic [CNT_W-1:0] diff;
   logic [ACC_W-1:0] total_base;
   logic [ACC_W:0]   sum;

   sync_bus #(.W(CNT_W)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (cnt_in),
      .q_o (s2)
   );

   // warm_q marks which pipeline stages hold real samples, so reset zeros are never accepted.
   always_comb begin
      stab_d = '0;
      if (warm_q[2] && (s2 == s2_prev_q)) begin
         stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1);
      end
      stable = warm_q[1] && (stab_d == STAB_MAX);
   end

   assign diff       = s2 - cnt_sync_q;
   assign total_base = clr ? '0 : total_q;
   assign sum        = {1'b0, total_base} + (ACC_W+1)'(diff);

   always_comb begin
      state_d    = state_q;
      cnt_sync_d = cnt_sync_q;
      valid_d    = valid_q;
      step_d     = 1'b0;
      delta_d    = '0;
      wrap_d     = 1'b0;
      total_d    = total_base;
      ovf_d      = clr ? 1'b0 : ovf_q;
      case (state_q)
         INIT: begin
            if (stable) begin
               cnt_sync_d = s2;
               valid_d    = 1'b1;
               state_d    = TRACK;
            end
         end
         TRACK: begin
            if (stable && (s2 != cnt_sync_q)) begin
               cnt_sync_d = s2;
               step_d     = 1'b1;
               delta_d    = diff;
               wrap_d     = (s2 < cnt_sync_q);
               total_d    = sum[ACC_W-1:0];
               if (sum[ACC_W]) ovf_d = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_prev_q  <= '0;
         warm_q     <= '0;
         stab_q     <= '0;
         state_q    <= INIT;
         cnt_sync_q <= '0;
         valid_q    <= 1'b0;
         step_q     <= 1'b0;
         delta_q    <= '0;
         wrap_q     <= 1'b0;
         total_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         s2_prev_q  <= s2;
         warm_q     <= {warm_q[1:0], 1'b1};
         stab_q     <= stab_d;
         state_q    <= state_d;
         cnt_sync_q <= cnt_sync_d;
         valid_q    <= valid_d;
         step_q     <= step_d;
         delta_q    <= delta_d;
         wrap_q     <= wrap_d;
         total_q    <= total_d;
         ovf_q      <= ovf_d;
      end
   end

   assign cnt_sync   = cnt_sync_q;
   assign valid      = valid_q;
   assign step_pulse = step_q;
   assign delta      = delta_q;
   assign wrap_pulse = wrap_q;
   assign total      = total_q;
   assign total_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_monitor.sv
`default_nettype none
// tb_ripple_count_monitor: per-cycle vector table plus directed reset and overflow sequences.
module tb_ripple_count_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [2:0]  cnt_in = 3'd0;

   logic [2:0]  cs, d;
   logic        v, sp, wr, ovf;
   logic [15:0] tot;

   logic [2:0]  cs4, d4;
   logic        v4, sp4, wr4, ovf4;
   logic [3:0]  tot4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ripple_count_monitor dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
      .cnt_sync(cs), .valid(v), .step_pulse(sp), .delta(d),
      .wrap_pulse(wr), .total(tot), .total_ovf(ovf)
   );

   ripple_count_monitor #(.ACC_W(4)) dut4 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
      .cnt_sync(cs4), .valid(v4), .step_pulse(sp4), .delta(d4),
      .wrap_pulse(wr4), .total(tot4), .total_ovf(ovf4)
   );

   typedef struct {
      logic        rst;
      logic [2:0]  cnt;
      logic        clr;
      logic [2:0]  ecs;
      logic        ev;
      logic        esp;
      logic [2:0]  ed;
      logic        ewr;
      logic [15:0] etot;
      logic        eovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [2:0] c, input logic cl,
                      input logic [2:0] ecs, input logic ev, input logic esp,
                      input logic [2:0] ed, input logic ewr, input logic [15:0] et,
                      input logic eo);
      vec_t t;
      t.rst = r; t.cnt = c; t.clr = cl; t.ecs = ecs; t.ev = ev; t.esp = esp;
      t.ed = ed; t.ewr = ewr; t.etot = et; t.eovf = eo;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pack_out();
      return {6'd0, cs, v, sp, d, wr, tot, ovf};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Steady 5 after reset: accepted at the 4th edge, never a step.
      add(0,5,0, 0,0,0,0,0,0,0);
      repeat (3) add(1,5,0, 0,0,0,0,0,0,0);
      add(1,5,0, 5,1,0,0,0,0,0);
      add(1,5,0, 5,1,0,0,0,0,0);
      // Baseline 3, then 4 preceded by one-cycle ripple codes 2 and 0.
      add(0,3,0, 0,0,0,0,0,0,0);
      repeat (3) add(1,3,0, 0,0,0,0,0,0,0);
      add(1,3,0, 3,1,0,0,0,0,0);
      add(1,2,0, 3,1,0,0,0,0,0);
      add(1,0,0, 3,1,0,0,0,0,0);
      repeat (3) add(1,4,0, 3,1,0,0,0,0,0);
      add(1,4,0, 4,1,1,1,0,1,0);
      add(1,4,0, 4,1,0,0,0,1,0);
      // Baseline 6, then 1: wraps with delta 3.
      add(0,6,0, 0,0,0,0,0,0,0);
      repeat (3) add(1,6,0, 0,0,0,0,0,0,0);
      add(1,6,0, 6,1,0,0,0,0,0);
      repeat (3) add(1,1,0, 6,1,0,0,0,0,0);
      add(1,1,0, 1,1,1,3,1,3,0);
      add(1,1,0, 1,1,0,0,0,3,0);
      // Build total 9, then clear coinciding with a delta-2 step, then clear alone.
      add(0,0,0, 0,0,0,0,0,0,0);
      repeat (3) add(1,0,0, 0,0,0,0,0,0,0);
      add(1,0,0, 0,1,0,0,0,0,0);
      repeat (3) add(1,7,0, 0,1,0,0,0,0,0);
      add(1,7,0, 7,1,1,7,0,7,0);
      repeat (3) add(1,1,0, 7,1,0,0,0,7,0);
      add(1,1,0, 1,1,1,2,1,9,0);
      repeat (3) add(1,3,0, 1,1,0,0,0,9,0);
      add(1,3,1, 3,1,1,2,0,2,0);
      add(1,3,0, 3,1,0,0,0,2,0);
      add(1,3,1, 3,1,0,0,0,0,0);
      add(1,3,0, 3,1,0,0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; cnt_in = tbl[i].cnt; clr = tbl[i].clr;
         cyc(1);
         check($sformatf("vec%0d", i), pack_out(),
               {6'd0, tbl[i].ecs, tbl[i].ev, tbl[i].esp, tbl[i].ed, tbl[i].ewr,
                tbl[i].etot, tbl[i].eovf});
      end
      clr = 1'b0;

      // Reset mid-TRACK with total 7 clears everything without waiting for an edge.
      rst = 1'b0; cnt_in = 3'd0; cyc(1);
      rst = 1'b1; cyc(4);
      check("rst_seq_base_valid", {31'd0, v}, 32'd1);
      cnt_in = 3'd7; cyc(4);
      check("rst_seq_total7", {16'd0, tot}, 32'd7);
      cyc(1);
      #3 rst = 1'b0;
      #1 check("rst_async_clear", pack_out(), 32'd0);
      cnt_in = 3'd2; cyc(2);
      rst = 1'b1;
      begin
         int pulses = 0;
         for (int e = 1; e <= 8; e++) begin
            cyc(1);
            if (sp) pulses++;
            if (e == 3) check("rst_seq_not_yet_valid", {31'd0, v}, 32'd0);
            if (e == 4) check("rst_seq_rebase", {28'd0, cs, v}, {28'd0, 3'd2, 1'b1});
         end
         check("rst_seq_no_step", pulses, 32'd0);
      end

      // Narrow accumulator overflow: 14 + 3 wraps to 1 and sets the sticky flag.
      rst = 1'b0; cnt_in = 3'd0; cyc(1);
      rst = 1'b1; cyc(4);
      cnt_in = 3'd7; cyc(4);
      cnt_in = 3'd6; cyc(4);
      check("ovf_pre_total14", {28'd0, tot4}, 32'd14);
      check("ovf_pre_flag", {31'd0, ovf4}, 32'd0);
      cnt_in = 3'd1; cyc(4);
      check("ovf_delta3", {29'd0, d4}, 32'd3);
      check("ovf_total_wrap", {28'd0, tot4}, 32'd1);
      check("ovf_flag_set", {31'd0, ovf4}, 32'd1);
      check("ovf_wide_total17", {16'd0, tot}, 32'd17);
      check("ovf_wide_flag", {31'd0, ovf}, 32'd0);
      cyc(2);
      check("ovf_sticky", {31'd0, ovf4}, 32'd1);
      clr = 1'b1; cyc(1);
      clr = 1'b0;
      check("clr_total", {28'd0, tot4}, 32'd0);
      check("clr_flag", {31'd0, ovf4}, 32'd0);
      check("clr_keeps_sync", {28'd0, cs4, v4}, {28'd0, 3'd1, 1'b1});
      cyc(1);
      check("clr_no_pulse", {30'd0, sp4, wr4}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit ripple up counter ({Qc,Qb,Qa}). The counter is clocked from an unrelated or derived edge, and its outputs settle through transient ripple states.
- This block brings the count into the clk domain, rejects ripple glitches with a stability filter, and reports each accepted change as a modular delta.
- It keeps a wide running total of counted edges for software and status logic.

Parameters:
- CNT_W, 3, width of the monitored ripple count.
- ACC_W, 16, width of the running total.
- STABLE_CYCLES, 2, consecutive identical synchronized samples required to accept a value; legal range 1..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cnt_in  input  CNT_W  raw ripple counter outputs, MSB=Qc, LSB=Qa; asynchronous to clk.
- clr  input  1  synchronous clear of total and total_ovf.
- cnt_sync  output  CNT_W  last accepted (filtered) count.
- valid  output  1  high once the first value has been accepted after reset.
- step_pulse  output  1  one-cycle pulse when an accepted value differs from the previous one.
- delta  output  CNT_W  (new - old) mod 2^CNT_W; valid only while step_pulse=1, otherwise 0.
- wrap_pulse  output  1  one-cycle pulse when step_pulse=1 and new < old (unsigned).
- total  output  ACC_W  running sum of all deltas.
- total_ovf  output  1  sticky; set when a total addition carries out of ACC_W bits.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and internal registers are 0; FSM is in INIT.
- Synchronizer: two flops, s1 <= cnt_in and s2 <= s1.
- Stability filter:
  - stab_cnt resets to 0 whenever s2 != s2_prev; otherwise it increments, saturating at STABLE_CYCLES-1.
  - "stable" means stab_cnt == STABLE_CYCLES-1.
  - Accepted value is s2.
- Latency: once cnt_in is steady, the outputs reflect it at the (STABLE_CYCLES+2)th rising edge (4 edges at default).
- FSM, two states:
  - INIT: on the first stable sample, cnt_sync <= s2, valid <= 1, go to TRACK. No step_pulse; total is unchanged (this sample is the baseline).
  - TRACK: on a stable sample with s2 != cnt_sync: cnt_sync <= s2; step_pulse <= 1; delta <= s2 - cnt_sync (CNT_W-bit wrap); wrap_pulse <= (s2 < cnt_sync); total <= total + delta, zero-extended.
  - TRACK: a stable sample equal to cnt_sync produces no pulse.
  - TRACK never returns to INIT except via reset.
- Pulses are registered, last exactly one cycle, and are never asserted in INIT.
- Overflow: if total + delta >= 2^ACC_W, total wraps modulo 2^ACC_W and total_ovf <= 1. total_ovf is cleared only by clr or reset.
- clr:
  - Alone: total <= 0, total_ovf <= 0. cnt_sync, valid and FSM state are unaffected.
  - Same cycle as an accepted step: total <= zero-extended delta, total_ovf <= 0. The clear applies first, then the add.
- Deltas of 2^CNT_W or more between accepted samples alias. This is legal and undetectable; the upstream counter must not advance more than 2^CNT_W - 1 within STABLE_CYCLES+2 clk cycles.
- Transient ripple codes (e.g. 3->2->0->4 on 3->4) held for fewer than STABLE_CYCLES samples are never accepted.
- Asserting rst mid-operation discards all history. After release, the next stable value becomes a fresh baseline.

Decomposition:
- Shared package ripple_mon_pkg:
  - state enum {INIT, TRACK};
  - localparam STAB_W = $clog2(STABLE_CYCLES) (minimum 1).
- One sub-module: sync_bus, a parameterized-width two-flop synchronizer with async active-low reset.
- FSM, filter and accumulator stay in ripple_count_monitor.

Test Plan:
- Reset, then cnt_in=5 held steady -> valid=1 at edge 4 with cnt_sync=5; step_pulse never asserts; total=0.
- Baseline 3, then cnt_in=4 with glitch codes 2 and 0 each held 1 clk -> exactly one step_pulse, delta=1, wrap_pulse=0, total=1.
- Baseline 6, then cnt_in=1 -> delta=3, wrap_pulse=1, total=3.
- ACC_W=4, total=14, then a step with delta=3 -> total=1, total_ovf=1. A later clr -> total=0, total_ovf=0, cnt_sync unchanged.
- clr asserted in the same cycle as an accepted step with delta=2 from total=9 -> total=2, total_ovf=0.
- rst pulsed low while in TRACK with total=7 -> all outputs 0 immediately; after release, cnt_in=2 steady -> valid=1, cnt_sync=2, no step_pulse.
